// File: rtl/codec_axi_lite_slave.sv
// AXI4-Lite slave front-end for the codec register bank.
// Turns AXI writes into a one-cycle strobe and reads into a captured read.
module codec_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                            axi_clk,
  input  logic                            axi_reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   data_in,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   data_out,
  output logic [C_S_AXI_ADDR_WIDTH-3:0]   reg_addr_wr,
  output logic [C_S_AXI_ADDR_WIDTH-3:0]   reg_addr_rd,
  output logic                            data_wren,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] byte_enable
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_STROBE,
    W_RESP
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CAPTURE,
    R_DATA
  } rstate_e;

  wstate_e         wstate_q;
  rstate_e         rstate_q;

  logic            awready_q;
  logic            wready_q;
  logic            bvalid_q;
  logic            arready_q;
  logic            rvalid_q;
  logic            wren_q;
  logic            aw_held_q;
  logic            w_held_q;
  logic [IW-1:0]   waddr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [IW-1:0]   addr_wr_q;
  logic [DW-1:0]   din_q;
  logic [SW-1:0]   be_q;
  logic [IW-1:0]   addr_rd_q;
  logic [DW-1:0]   rdata_q;

  logic            aw_hs;
  logic            w_hs;
  logic            aw_held_d;
  logic            w_held_d;
  logic [IW-1:0]   waddr_d;
  logic [DW-1:0]   wdata_d;
  logic [SW-1:0]   wstrb_d;

  logic            unused;

  // Protection bits and byte-lane address bits carry no meaning here.
  assign unused = ^{s_axi_awprot, s_axi_arprot,
                    s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Fold this cycle's AW/W handshakes into the held address/data.
  always_comb begin
    aw_hs     = s_axi_awvalid & awready_q;
    w_hs      = s_axi_wvalid & wready_q;
    aw_held_d = aw_held_q | aw_hs;
    w_held_d  = w_held_q | w_hs;
    waddr_d   = aw_hs ? s_axi_awaddr[AW-1:2] : waddr_q;
    wdata_d   = w_hs ? s_axi_wdata : wdata_q;
    wstrb_d   = w_hs ? s_axi_wstrb : wstrb_q;
  end

  // Write FSM: collect AW and W, strobe the bank once, then respond.
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      wren_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      addr_wr_q <= '0;
      din_q     <= '0;
      be_q      <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wren_q    <= 1'b0;
      unique case (wstate_q)
        W_IDLE: begin
          if (aw_held_d && w_held_d) begin
            wstate_q  <= W_STROBE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wren_q    <= 1'b1;
            addr_wr_q <= waddr_d;
            din_q     <= wdata_d;
            be_q      <= wstrb_d;
          end else begin
            awready_q <= ~aw_held_d;
            wready_q  <= ~w_held_d;
          end
        end
        W_STROBE: begin
          wstate_q <= W_RESP;
          bvalid_q <= 1'b1;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: latch index, sample bank data one cycle later, respond.
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      addr_rd_q <= '0;
      rdata_q   <= '0;
    end else begin
      unique case (rstate_q)
        R_IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            rstate_q  <= R_CAPTURE;
            arready_q <= 1'b0;
            addr_rd_q <= s_axi_araddr[AW-1:2];
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_CAPTURE: begin
          rstate_q <= R_DATA;
          rdata_q  <= data_out;
          rvalid_q <= 1'b1;
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rdata   = rdata_q;
  assign data_wren     = wren_q;
  assign reg_addr_wr   = addr_wr_q;
  assign data_in       = din_q;
  assign byte_enable   = be_q;
  assign reg_addr_rd   = addr_rd_q;

endmodule

// File: doc/codec_axi_lite_slave.md
Name: codec_axi_lite_slave

Overview:
AXI4-Lite slave front-end for the codec register bank. It terminates the PS AXI4-Lite master and converts each write transaction into a single-cycle register write strobe. It converts each read transaction into a register read address plus a one-shot capture of the register bank's combinational read data. It sits directly upstream of the codec register bank, in the axi_clk domain.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 8, AXI byte-address width; register index = addr[7:2]

Ports:
axi_clk  in  1  AXI clock
axi_reset  in  1  asynchronous active-low reset
s_axi_awaddr  in  8  write address (byte)
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  write byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response, always 2'b00 OKAY
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  8  read address (byte)
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response, always 2'b00 OKAY
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
data_in  out  32  write data to register bank
data_out  in  32  combinational read data from register bank
reg_addr_wr  out  6  write register index
reg_addr_rd  out  6  read register index
data_wren  out  1  single-cycle write strobe
byte_enable  out  4  latched wstrb

Behaviour:
- Reset (axi_reset low, asynchronous): all outputs 0.
  - Write FSM → W_IDLE; read FSM → R_IDLE; aw_held and w_held cleared.
  - Ready outputs rise on the first clock edge after reset deasserts.
- All outputs are registered.
- Write FSM states: W_IDLE, W_STROBE, W_RESP.
  - W_IDLE: s_axi_awready = ~aw_held; s_axi_wready = ~w_held.
  - AW handshake latches awaddr[7:2] and sets aw_held. W handshake latches wdata/wstrb and sets w_held.
  - AW and W may arrive in the same cycle or in either order, any gap apart.
  - When both are held, the FSM moves to W_STROBE on the next edge. Both readys are low from then until return to W_IDLE.
  - W_STROBE lasts exactly 1 cycle: data_wren = 1, with reg_addr_wr, data_in and byte_enable valid.
  - Then W_RESP: s_axi_bvalid = 1, bresp = OKAY. Held until bready; on handshake, clear the held flags and return to W_IDLE.
- Write latency: AW and W handshaked together in cycle T → data_wren in T+1 → bvalid in T+2.
- At most one outstanding write. No new AW/W is accepted until the B handshake completes.
- data_wren is 0 in every cycle except W_STROBE.
- reg_addr_wr, data_in and byte_enable hold their last values outside W_STROBE.
- Read FSM states: R_IDLE, R_CAPTURE, R_DATA.
  - R_IDLE: s_axi_arready = 1. AR handshake latches araddr[7:2] into reg_addr_rd and moves to R_CAPTURE.
  - R_CAPTURE lasts 1 cycle: data_out is sampled into s_axi_rdata at the end of the cycle.
  - R_DATA: s_axi_rvalid = 1, rresp = OKAY. rdata is stable until rready; on handshake return to R_IDLE.
- Read latency: AR handshake in T → rvalid in T+2.
- arready is low in R_CAPTURE and R_DATA. reg_addr_rd holds the last read index after completion.
- Read and write FSMs are independent and may run concurrently.
  - If W_STROBE and R_CAPTURE coincide on the same register, rdata returns the pre-write value.
- Address bits [1:0] are ignored. Unmapped indices are passed through unchanged; the bank returns 32'hdeadbeef. The response is always OKAY.
- Reset mid-transaction: the transaction is abandoned, with no data_wren and no bvalid/rvalid after reset.
- bvalid/rvalid are never deasserted before their ready (AXI rule). awready/wready/arready do not depend combinationally on valid.

Test Plan:
1. Reset release → all outputs 0 during reset; awready = wready = arready = 1 on first edge after; data_wren = 0.
2. AW 0x04 and W 0x0000_1234 (wstrb 4'hF) in same cycle T → data_wren = 1 only in T+1 with reg_addr_wr = 6'h01, data_in = 32'h1234, byte_enable = 4'hF; bvalid in T+2, bresp = 0.
3. W 0xA5A5_A5A5 at T, AW 0x08 at T+3 → wready low from T+1; data_wren at T+4, reg_addr_wr = 6'h02; bready held low 5 cycles → bvalid stays high, no second strobe.
4. AR 0x0C with data_out driven 32'hCAFECAFE → reg_addr_rd = 6'h03, rvalid at T+2 with rdata = 32'hCAFECAFE; rready held low 3 cycles → rdata stable while data_out changes.
5. Concurrent write and read to 0x04 (old 0x0, new 0x55) with AW/W/AR all at T → rdata = 0x0, data_wren at T+1; both responses OKAY.
6. axi_reset asserted in W_RESP and in R_CAPTURE → bvalid/rvalid drop immediately; after release, no spurious data_wren or response.
